// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: round-robin ALU/LSU writeback arbiter with registered RF write port and busy scoreboard
module rf_wb_scheduler #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic            iss_rs1_valid,
  input  logic            iss_rs2_valid,
  input  logic [4:0]      iss_rd,
  input  logic            iss_rd_we,
  output logic            iss_stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            rf_wr_en,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_result,
  output logic [31:0]     busy
);
  logic            last_lsu;
  logic            xfer;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [31:0]     set_v;
  logic [31:0]     clr_v;
  // last_lsu set means LSU took the most recent contended grant, so ALU wins the next one
  assign alu_ready = alu_valid && (!lsu_valid || last_lsu);
  assign lsu_ready = lsu_valid && (!alu_valid || !last_lsu);
  assign xfer      = alu_ready || lsu_ready;
  assign wb_rd     = lsu_ready ? lsu_rd : alu_rd;
  assign wb_data   = lsu_ready ? lsu_data : alu_data;
  assign iss_stall = iss_valid && ((iss_rs1_valid && busy[iss_rs1]) ||
                                   (iss_rs2_valid && busy[iss_rs2]) ||
                                   (iss_rd_we && busy[iss_rd]));
  always_comb begin
    set_v = (iss_valid && !iss_stall && iss_rd_we) ? (32'd1 << iss_rd) : 32'd0;
    clr_v = rf_wr_en ? (32'd1 << rf_rd) : 32'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      last_lsu  <= 1'b0;
      rf_wr_en  <= 1'b0;
      rf_rd     <= '0;
      rf_result <= '0;
    end else begin
      busy     <= ((busy & ~clr_v) | set_v) & ~32'd1;
      rf_wr_en <= xfer && (wb_rd != 5'd0);
      if (alu_valid && lsu_valid) last_lsu <= lsu_ready;
      if (xfer) begin
        rf_rd     <= wb_rd;
        rf_result <= wb_data;
      end
    end
  end
endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-port scheduler and hazard scoreboard for the 32×32 integer register file (`registerf`: combinational reads, one synchronous write port, x0 hard-wired to zero). It shares the single write port between the ALU and LSU writeback sources using round-robin arbitration with valid/ready handshakes. It registers the winning write onto the register-file port and keeps a per-register busy scoreboard that stalls issue on RAW/WAW hazards.

## Interface
- XLEN, 32, data width of writeback and register-file data
- Register address width is fixed at 5; x0 is never busy and never written
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- iss_valid  in  1  instruction presented for issue
- iss_rs1, iss_rs2  in  5 each  source register indices
- iss_rs1_valid, iss_rs2_valid  in  1 each  source operand is used
- iss_rd  in  5  destination register index
- iss_rd_we  in  1  instruction writes rd
- iss_stall  out  1  combinational; issue must not complete this cycle
- alu_valid  in  1  ALU writeback request
- alu_rd  in  5  ALU writeback destination
- alu_data  in  XLEN  ALU writeback data
- alu_ready  out  1  combinational ALU grant
- lsu_valid  in  1  LSU load writeback request
- lsu_rd  in  5  LSU writeback destination
- lsu_data  in  XLEN  LSU writeback data
- lsu_ready  out  1  combinational LSU grant
- rf_wr_en  out  1  registered write enable to register file
- rf_rd  out  5  registered write index
- rf_result  out  XLEN  registered write data
- busy  out  32  scoreboard; bit r set means register r has an outstanding write

## Operation
- **Handshake.** A transfer occurs on a rising edge when valid && ready. A source must hold valid, rd and data stable until ready. At most one grant is issued per cycle.
- **Arbitration.**
  - Only one source valid: that source is granted.
  - Both sources valid: the source not granted at the last contended grant wins.
  - Pointer `last` updates only on contended grants. Reset value is ALU, so LSU wins the first conflict.
  - Neither source starves: each waits at most one contended grant.
- **Output register.** On a transfer:
  - rf_rd ← rd and rf_result ← data.
  - rf_wr_en ← (rd != 0).
  - Without a transfer, rf_wr_en ← 0; rf_rd and rf_result hold their values.
  - A transfer with rd=0 is accepted and consumed, but produces no write.
- **Stall.** iss_stall = iss_valid && ((iss_rs1_valid && busy[iss_rs1]) || (iss_rs2_valid && busy[iss_rs2]) || (iss_rd_we && busy[iss_rd])). This covers both RAW and WAW hazards.
- **Scoreboard set.** Issue completes when iss_valid && !iss_stall. If that issue also has iss_rd_we && iss_rd != 0, busy[iss_rd] is set at the edge.
- **Scoreboard clear.** busy[rf_rd] is cleared at the edge where rf_wr_en=1. This is the same edge on which the register file captures the data, so a dependent read issued in the following cycle sees the new value.
- **Simultaneous set and clear** of the same register at one edge: set wins. A stale writeback to a non-busy register clears nothing and reports no error.
- busy[0] is constant 0.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): busy=0, rf_wr_en=0, rf_rd=0, rf_result=0, `last`=ALU. While reset is asserted, alu_ready, lsu_ready and iss_stall follow their equations.
- Reset asserted mid-operation:
  - Outstanding busy bits are dropped.
  - A write pending in the output register is lost.
  - Sources must re-present their requests after reset release.
- Grant is combinational in the request cycle. Transfer at edge N → rf_wr_en=1 during cycle N+1 → RF written and busy cleared at edge N+1. A dependent instruction can issue in cycle N+2.
- Throughput is one writeback per cycle. Back-to-back transfers produce rf_wr_en held high continuously.
- iss_stall, alu_ready and lsu_ready have no dependence on each other, so there are no combinational loops.

## Test plan
- **Reset values.** Assert rst_n=0 mid-run with busy=0x0000_0006 → busy=0, rf_wr_en=0, rf_rd=0 and rf_result=0 immediately, without waiting for a clock.
- **RAW stall.** Issue rd=5 (iss_rd_we=1) → busy[5]=1. Present rs1=5 → iss_stall=1. ALU writes rd=5 data=0xDEADBEEF → rf_wr_en=1, rf_rd=5. At the next edge busy[5]=0 and iss_stall=0. Register 5 reads 0xDEADBEEF.
- **Contention.** Hold alu_valid=1 (rd=3, 0x11) and lsu_valid=1 (rd=4, 0x22) together from reset → LSU is granted first, ALU in the next cycle. rf_rd sequence is 4, 3 and rf_wr_en stays high for 2 cycles.
- **Fairness.** Keep both sources valid for 6 cycles → grants alternate LSU, ALU, LSU, ALU, … with no source granted twice in a row.
- **x0 handling.** ALU writeback with rd=0, data=0xFFFF_FFFF → alu_ready=1, rf_wr_en stays 0, busy unchanged. Issue with rd=0 → busy stays 0.
- **Set/clear collision.** busy[7]=1 with writeback rf_rd=7 in flight. In the same cycle, issue an instruction with iss_rd=7 and force iss_stall low in the bench → busy[7]=1 after the edge (set wins).
